// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one shared full-adder cell LSB-first over
// WIDTH cycles, with a start/busy/done handshake and held result registers.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, sha_d;
    logic [WIDTH-1:0]   shb_q, shb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cell_sum_s;
    logic               cell_carry_s;

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d      = state_q;
        sha_d        = sha_q;
        shb_d        = shb_q;
        res_d        = res_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        cell_sum_s   = fa_sum(sha_q[0], shb_q[0], carry_q);
        cell_carry_s = fa_carry(sha_q[0], shb_q[0], carry_q);

        if (clear) begin
            // Abort discards the in-flight operation; sum/cout keep their last value.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        sha_d   = a;
                        shb_d   = b;
                        carry_d = cin;
                        res_d   = {WIDTH{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sha_d   = {1'b0, sha_q[WIDTH-1:1]};
                    shb_d   = {1'b0, shb_q[WIDTH-1:1]};
                    res_d   = {cell_sum_s, res_q[WIDTH-1:1]};
                    carry_d = cell_carry_s;
                    if (cnt_q == CNT_LAST) begin
                        // Last bit: publish the completed word, counter parks at zero.
                        state_d = ST_DONE;
                        sum_d   = {cell_sum_s, res_q[WIDTH-1:1]};
                        cout_d  = cell_carry_s;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sha_q   <= {WIDTH{1'b0}};
            shb_q   <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for a single 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)), reused LSB-first over WIDTH cycles to add two WIDTH-bit operands.
- Holds the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Sits between a requesting datapath and the shared full-adder cell. Trades latency for area in the combinational-circuit library.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE or DONE
clear  input  1  synchronous abort; forces IDLE, results unchanged
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result becomes valid
sum  output  WIDTH  result; stable from done until next accepted start completes
cout  output  1  final carry-out; same validity as sum

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n=0 forces state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry FF=0, shift regs=0, immediately and independent of clk.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge, load shA<=a, shB<=b, carry<=cin, cnt<=0, go to RUN.
- RUN: busy=1. Each edge:
  - feeds shA[0], shB[0], carry to the full-adder cell;
  - shifts the sum bit into the MSB of the result shift register (right shift);
  - carry<=cell carry; shA/shB shift right; cnt<=cnt+1.
- RUN exit: when cnt==WIDTH-1 at an edge, that edge processes the last bit. The final sum/cout are written to the output registers and state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0. At the next edge:
  - start=1 -> accept new operands exactly as from IDLE (back-to-back, go to RUN);
  - start=0 -> go to IDLE.
- Latency: start accepted at edge k -> bits processed on edges k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Result visibility:
  - sum/cout output registers update only at the RUN->DONE edge;
  - the internal result shift register is not visible on sum during RUN;
  - the previous result holds until then.
- start while in RUN: ignored, with no effect on the operation in flight.
- clear=1 at any edge: state<=IDLE, busy=0, done=0; in-flight operation discarded; sum/cout keep their last valid values. clear has priority over start at the same edge.
- Width rules:
  - sum is the low WIDTH bits of a+b+cin;
  - cout is bit WIDTH;
  - no overflow flag; no signed interpretation.
- Counter: cnt is CNT_W bits, compares against WIDTH-1, never wraps past it. For a non-power-of-2 WIDTH the unused codes are unreachable.
- Operands may change on the inputs during RUN without affecting the result, since they are captured at start.
- Reset mid-RUN: outputs go to reset values immediately. After rst_n deasserts, the block waits in IDLE for a new start.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, 1-cycle start pulse -> busy high 8 cycles; done pulses once 8 cycles after start edge; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulse re-asserted with a=0x11, b=0x22 at the 3rd RUN cycle of 0x5A+0x3C -> ignored; result 0x96/0; exactly one done pulse.
- start held high continuously with a=0x01, b=0x02, then a=0x10, b=0x20 presented at the DONE cycle:
  - done pulses every 9 cycles;
  - second result 0x30 with no idle cycle between.
- rst_n low for 1 cycle mid-RUN (cycle 4) -> busy=0, done=0, sum=0, cout=0 asynchronously; no done afterwards until a new start. A new start of 0x80+0x80 then gives sum=0x00, cout=1.
- clear=1 at RUN cycle 5 after a previous result 0x96 -> IDLE, no done, sum stays 0x96. clear and start high at the same IDLE edge -> remains IDLE.
